// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial n-bit adder: s = (a + b) mod 2^n, one bit per clock, LSB
//   first. The datapath is one full_adder plus a carry flop. It is the
//   inverse of the parallel n-bit subtractor that sits beside it in the
//   datapath, so (a - b) + b returns a modulo 2^n.
//
//   Parameters
//     n      operand/result width in bits (n >= 1)
//
//   Ports
//     clk    system clock, rising edge
//     rst    asynchronous, active-high reset
//     start  begin an addition; only looked at in IDLE
//     a, b   operands, captured on the accepted start edge
//     s      registered sum, holds the last result
//     cout   registered carry out of bit n-1, holds the last result
//     busy   high in ADD and DONE
//     done   one-cycle pulse, s/cout were just updated
//
//   Timing: start sampled at edge E0, ADD runs edges E0+1..E0+n, done is
//   high in the cycle after E0+n, IDLE is re-entered at E0+n+1.
// ---------------------------------------------------------------------------

// Single-bit full adder used by the serial datapath.
//   x, y  addend bits
//   cin   carry in
//   sum   sum bit
//   cout  carry out
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] s,
   output logic         cout,
   output logic         busy,
   output logic         done
);

   // A 1-bit counter is kept even for n=1 so the compare below stays legal.
   localparam int CW = (n > 1) ? $clog2(n) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_reg;
   state_t         state_next;

   logic [n-1:0]   a_sh_reg;
   logic [n-1:0]   b_sh_reg;
   logic [n-1:0]   r_reg;       // partial result, filled from the MSB side
   logic           carry_reg;
   logic [CW-1:0]  count_reg;

   logic           sum_bit;
   logic           carry_out;
   logic           last_bit;
   logic [n-1:0]   r_shift;

   full_adder u_fa (
      .x    (a_sh_reg[0]),
      .y    (b_sh_reg[0]),
      .cin  (carry_reg),
      .sum  (sum_bit),
      .cout (carry_out)
   );

   // Bit n-1 is being processed on this edge.
   assign last_bit = (count_reg == CW'(n - 1));

   // New sum bit enters at the MSB while older bits move right. After n
   // shifts bit 0 of the sum has reached r[0]. Written as a shifted
   // concatenation so it also holds for n=1, where r_shift is just sum_bit.
   assign r_shift = n'({sum_bit, r_reg} >> 1);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)    state_next = ADD;
         ADD:     if (last_bit) state_next = DONE;
         DONE:                  state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs, pure state decode
   // ---------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         ADD:     busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath. s/cout are written only on the final ADD edge, so the
   // outputs never show partial sums and keep the previous result while
   // a new addition is in flight.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         r_reg     <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         s         <= '0;
         cout      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh_reg  <= a;
                  b_sh_reg  <= b;
                  r_reg     <= '0;
                  carry_reg <= 1'b0;   // carry-in is fixed at 0
                  count_reg <= '0;
               end
            end
            ADD: begin
               a_sh_reg  <= a_sh_reg >> 1;
               b_sh_reg  <= b_sh_reg >> 1;
               r_reg     <= r_shift;
               carry_reg <= carry_out;
               count_reg <= count_reg + CW'(1);
               if (last_bit) begin
                  s    <= r_shift;
                  cout <= carry_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Drives three serial_adder instances (n = 4, 1, 8) from one clock and
//   reset. A reference model built from the latency rules and plain integer
//   addition is checked against every instance on every cycle. Directed
//   operations add literal expectations on top of that.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start4, start1, start8;
   logic [3:0] a4, b4, s4;
   logic [0:0] a1, b1, s1;
   logic [7:0] a8, b8, s8;
   logic       cout4, busy4, done4;
   logic       cout1, busy1, done1;
   logic       cout8, busy8, done8;

   serial_adder #(.n(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .s(s4), .cout(cout4), .busy(busy4), .done(done4)
   );
   serial_adder #(.n(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .s(s1), .cout(cout1), .busy(busy1), .done(done1)
   );
   serial_adder #(.n(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .s(s8), .cout(cout8), .busy(busy8), .done(done8)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- accessors (index 0: n=4, 1: n=1, 2: n=8) -------------
   function automatic int width_of(int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int get_s(int k);
      case (k)
         0:       return int'(s4);
         1:       return int'(s1);
         default: return int'(s8);
      endcase
   endfunction

   function automatic int get_c(int k);
      case (k)
         0:       return int'(cout4);
         1:       return int'(cout1);
         default: return int'(cout8);
      endcase
   endfunction

   function automatic int get_busy(int k);
      case (k)
         0:       return int'(busy4);
         1:       return int'(busy1);
         default: return int'(busy8);
      endcase
   endfunction

   function automatic int get_done(int k);
      case (k)
         0:       return int'(done4);
         1:       return int'(done1);
         default: return int'(done8);
      endcase
   endfunction

   function automatic int get_start(int k);
      case (k)
         0:       return int'(start4);
         1:       return int'(start1);
         default: return int'(start8);
      endcase
   endfunction

   function automatic int get_a(int k);
      case (k)
         0:       return int'(a4);
         1:       return int'(a1);
         default: return int'(a8);
      endcase
   endfunction

   function automatic int get_b(int k);
      case (k)
         0:       return int'(b4);
         1:       return int'(b1);
         default: return int'(b8);
      endcase
   endfunction

   task automatic drive(input int k, input bit st, input int av, input int bv);
      case (k)
         0: begin start4 = st; a4 = 4'(av); b4 = 4'(bv); end
         1: begin start1 = st; a1 = 1'(av); b1 = 1'(bv); end
         default: begin start8 = st; a8 = 8'(av); b8 = 8'(bv); end
      endcase
   endtask

   task automatic check(input string name, input int k, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s [n=%0d] at %0t: got %0d, expected %0d",
                  name, width_of(k), $time, got, exp);
      end
   endtask

   // ---------------- reference model + per-cycle compare ------------------
   // ph counts edges since the accepted start edge: busy for ph in [0, n],
   // done and the result update at ph == n, idle again at ph == n+1.
   bit act   [3];
   int ph    [3];
   int pend  [3];
   int exp_s [3];
   int exp_c [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         act[k] = 1'b0; ph[k] = 0; pend[k] = 0; exp_s[k] = 0; exp_c[k] = 0;
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            int w;
            w = width_of(k);
            if (rst) begin
               act[k] = 1'b0; ph[k] = 0; exp_s[k] = 0; exp_c[k] = 0;
            end else if (!act[k]) begin
               if (get_start(k) != 0) begin
                  act[k]  = 1'b1;
                  ph[k]   = 0;
                  pend[k] = get_a(k) + get_b(k);
               end
            end else begin
               ph[k]++;
               if (ph[k] == w) begin
                  exp_s[k] = pend[k] % (1 << w);
                  exp_c[k] = (pend[k] >> w) & 1;
               end else if (ph[k] > w) begin
                  act[k] = 1'b0;
               end
            end
         end
         #1;
         for (int k = 0; k < 3; k++) begin
            check("cyc_busy", k, get_busy(k), int'(act[k]));
            check("cyc_done", k, get_done(k), (act[k] && ph[k] == width_of(k)) ? 1 : 0);
            check("cyc_s",    k, get_s(k), exp_s[k]);
            check("cyc_cout", k, get_c(k), exp_c[k]);
         end
      end
   end

   // ---------------- one complete operation -------------------------------
   task automatic do_op(input int k, input int av, input int bv,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output int rs, output int rc);
      bit seen;
      @(posedge clk); #2;
      drive(k, 1'b1, av, bv);
      @(posedge clk);                 // E0: start accepted
      #1;
      busy_cnt = get_busy(k);
      done_cnt = get_done(k);
      lat      = 0;
      seen     = 1'b0;
      #1;
      drive(k, 1'b0, av, bv);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         busy_cnt += get_busy(k);
         done_cnt += get_done(k);
         if (get_done(k) != 0) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout [n=%0d]: got no done in %0d cycles, expected done after %0d",
                  width_of(k), lat, width_of(k));
      end
      rs = get_s(k);
      rc = get_c(k);
      @(posedge clk); #1;
      busy_cnt += get_busy(k);
      done_cnt += get_done(k);
      $display("op n=%0d a=%0d b=%0d -> s=%0d cout=%0d latency=%0d",
               width_of(k), av, bv, rs, rc, lat);
   endtask

   // ---------------- watchdog ---------------------------------------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ---------------------------
   initial begin
      int lat, bc, dc, rs, rc;
      rst = 1'b1;
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      drive(2, 1'b0, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_s",    k, get_s(k), 0);
         check("rst_cout", k, get_c(k), 0);
         check("rst_busy", k, get_busy(k), 0);
         check("rst_done", k, get_done(k), 0);
      end
      #2 rst = 1'b0;

      // 5 + 3
      do_op(0, 5, 3, lat, bc, dc, rs, rc);
      check("lat_5p3",  0, lat, 4);
      check("s_5p3",    0, rs, 8);
      check("c_5p3",    0, rc, 0);
      check("busy_len", 0, bc, 5);
      check("done_len", 0, dc, 1);

      // Carry boundaries
      do_op(0, 15, 1, lat, bc, dc, rs, rc);
      check("s_15p1", 0, rs, 0);
      check("c_15p1", 0, rc, 1);
      do_op(0, 15, 15, lat, bc, dc, rs, rc);
      check("s_15p15", 0, rs, 14);
      check("c_15p15", 0, rc, 1);

      // Starts during ADD and DONE are ignored; operand changes have no effect
      @(posedge clk); #2 drive(0, 1'b1, 9, 6);
      @(posedge clk);                       // E0
      #2 drive(0, 1'b0, 9, 6);
      @(posedge clk);                       // E0+1
      #2 drive(0, 1'b1, 1, 1);              // sampled at E0+2, in ADD
      @(posedge clk);
      #2 drive(0, 1'b0, 3, 12);             // operands change mid-ADD
      @(posedge clk);                       // E0+3
      @(posedge clk);                       // E0+4 -> DONE
      #1;
      check("ign_done", 0, get_done(0), 1);
      check("ign_s",    0, get_s(0), 15);
      check("ign_c",    0, get_c(0), 0);
      #1 drive(0, 1'b1, 1, 1);              // sampled at E0+5, in DONE
      @(posedge clk);
      #2 drive(0, 1'b0, 0, 0);
      dc = 0;
      repeat (10) begin
         @(posedge clk); #1;
         dc += get_done(0);
      end
      check("ign_extra_done", 0, dc, 0);
      check("ign_s_hold",     0, get_s(0), 15);

      // Asynchronous reset mid-ADD
      @(posedge clk); #2 drive(0, 1'b1, 7, 7);
      @(posedge clk);                       // E0
      #2 drive(0, 1'b0, 7, 7);
      @(posedge clk);                       // E0+1
      @(posedge clk);                       // E0+2
      #3 rst = 1'b1;
      #1;
      check("arst_s",    0, get_s(0), 0);
      check("arst_cout", 0, get_c(0), 0);
      check("arst_busy", 0, get_busy(0), 0);
      check("arst_done", 0, get_done(0), 0);
      @(posedge clk);
      #3 rst = 1'b0;
      dc = 0;
      repeat (8) begin
         @(posedge clk); #1;
         dc += get_done(0);
      end
      check("arst_no_done", 0, dc, 0);
      do_op(0, 2, 2, lat, bc, dc, rs, rc);
      check("s_2p2", 0, rs, 4);
      check("c_2p2", 0, rc, 0);

      // Exhaustive n=4
      for (int av = 0; av < 16; av++) begin
         for (int bv = 0; bv < 16; bv++) begin
            do_op(0, av, bv, lat, bc, dc, rs, rc);
            check("exh_s",   0, rs, (av + bv) % 16);
            check("exh_c",   0, rc, (av + bv) / 16);
            check("exh_lat", 0, lat, 4);
         end
      end

      // n=1, all operand pairs
      for (int av = 0; av < 2; av++) begin
         for (int bv = 0; bv < 2; bv++) begin
            do_op(1, av, bv, lat, bc, dc, rs, rc);
            check("n1_lat", 1, lat, 1);
            check("n1_s",   1, rs, av ^ bv);
            check("n1_c",   1, rc, av & bv);
            check("n1_busy_len", 1, bc, 2);
         end
      end

      // n=8
      do_op(2, 200, 100, lat, bc, dc, rs, rc);
      check("n8_lat", 2, lat, 8);
      check("n8_s",   2, rs, 44);
      check("n8_c",   2, rc, 1);

      // Random traffic on all three instances, start requests at any time
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #2;
         for (int k = 0; k < 3; k++) begin
            drive(k, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
         end
      end
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 0, 0);
      repeat (12) @(posedge clk);
      #3;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
